// File: rtl/beep_pkg.sv
// -----------------------------------------------------------------------------
// beep_pkg
//   Shared definitions for the beep sequencer: FSM state encoding, default
//   timing constants and a constant-evaluable ceil(log2) helper.
// -----------------------------------------------------------------------------
package beep_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } beep_state_t;

   // Defaults target a 100 MHz clock: ~1046 Hz tone, 0.5 s beep, 0.5 s gap.
   localparam int unsigned N_REQ_DEF    = 4;
   localparam int unsigned TONE_DIV_DEF = 95602;
   localparam int unsigned ON_CYC_DEF   = 50000000;
   localparam int unsigned OFF_CYC_DEF  = 50000000;

   // ceil(log2(n)), never less than 1 so it can size a vector directly.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// -----------------------------------------------------------------------------
// beep_tone_gen
//   Square-wave generator of period TONE_DIV cycles. The output is high for
//   counter values >= TONE_DIV/2 and is registered.
//
//   en is a look-ahead: it is high when the coming cycle is a tone cycle. The
//   counter restarts at 0 on the first tone cycle after en was low, so every
//   burst begins with the low half of the period.
//
// Ports
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   en    in   next cycle is a tone cycle
//   tone  out  registered square wave, 0 whenever the current cycle is not a
//              tone cycle
// -----------------------------------------------------------------------------
module beep_tone_gen
   import beep_pkg::*;
#(
   parameter int unsigned TONE_DIV = TONE_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tone
);

   localparam int unsigned TW = clog2(TONE_DIV);

   logic [TW-1:0] r_cnt;      // tone phase of the current cycle
   logic          r_run;      // current cycle is a tone cycle
   logic          r_tone;
   logic [TW-1:0] w_cnt_next;

   // Phase for the coming cycle: 0 on a fresh burst, else wrap at TONE_DIV-1.
   assign w_cnt_next = !r_run                       ? '0 :
                       (r_cnt == TW'(TONE_DIV - 1)) ? '0 :
                                                      r_cnt + TW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_run  <= 1'b0;
         r_tone <= 1'b0;
      end else begin
         r_run  <= en;
         r_cnt  <= en ? w_cnt_next : '0;
         r_tone <= en && (w_cnt_next >= TW'(TONE_DIV / 2));
      end
   end

   assign tone = r_tone;

endmodule

// File: rtl/beep_sequencer.sv
// -----------------------------------------------------------------------------
// beep_sequencer
//   Shares one speaker between N_REQ alert sources. Requester i plays i+1
//   beeps; each beep is ON_CYC cycles of tone followed by OFF_CYC cycles of
//   silence. Higher index means higher priority. Requests are level-sampled
//   into a pending register, so repeats while pending merge into one pattern,
//   and a request during the requester's own playback queues a replay.
//
//   Optional build macro BEEP_PREEMPT_EN: a pending request with a higher
//   index than the playing one aborts the current pattern (no done pulse,
//   its pending bit is set again so it replays from the start later).
//   Without it, every pattern runs to completion.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   req      in   [N_REQ]  request bits, bit i high for 1+ cycles
//   done     out  [N_REQ]  one-cycle pulse on bit i when pattern i completes
//   busy     out  high while a pattern plays
//   active   out  [clog2(N_REQ)]  index of the playing requester, 0 when idle
//   speaker  out  registered tone output
// -----------------------------------------------------------------------------
module beep_sequencer
   import beep_pkg::*;
#(
   parameter int unsigned N_REQ    = N_REQ_DEF,
   parameter int unsigned TONE_DIV = TONE_DIV_DEF,
   parameter int unsigned ON_CYC   = ON_CYC_DEF,
   parameter int unsigned OFF_CYC  = OFF_CYC_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   output logic [N_REQ-1:0]          done,
   output logic                      busy,
   output logic [clog2(N_REQ)-1:0]   active,
   output logic                      speaker
);

   localparam int unsigned AW   = clog2(N_REQ);
   localparam int unsigned BW   = clog2(N_REQ + 1);
   localparam int unsigned MAXC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int unsigned CW   = clog2(MAXC);

   beep_state_t      r_state;
   logic [N_REQ-1:0] r_pending;
   logic [AW-1:0]    r_active;
   logic [BW-1:0]    r_beeps_left;
   logic [CW-1:0]    r_phase_cnt;
   logic [N_REQ-1:0] r_done;

   logic [AW-1:0]    w_grant_idx;
   logic             w_grant_go;
   logic             w_last_on;
   logic             w_last_off;
   logic             w_abort;
   logic [N_REQ-1:0] w_pend_next;
   logic             w_tone_en;
   logic             w_tone;

   // Highest set pending bit wins; the last assignment in the loop is the top.
   always_comb begin
      w_grant_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_pending[i]) begin
            w_grant_idx = AW'(i);
         end
      end
   end

   assign w_grant_go = (r_state == S_IDLE) && (r_pending != '0);
   assign w_last_on  = (r_state == S_ON)  && (r_phase_cnt == CW'(ON_CYC - 1));
   assign w_last_off = (r_state == S_OFF) && (r_phase_cnt == CW'(OFF_CYC - 1));

`ifdef BEEP_PREEMPT_EN
   logic w_higher_pend;

   always_comb begin
      w_higher_pend = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_pending[i] && (i > int'(r_active))) begin
            w_higher_pend = 1'b1;
         end
      end
   end

   assign w_abort = (r_state != S_IDLE) && w_higher_pend;
`else
   assign w_abort = 1'b0;
`endif

   // New requests merge in; the granted bit clears; an aborted pattern
   // re-arms its own bit so it replays from the start.
   always_comb begin
      w_pend_next = r_pending | req;
      if (w_grant_go) begin
         w_pend_next[w_grant_idx] = 1'b0;
      end
      if (w_abort) begin
         w_pend_next[r_active] = 1'b1;
      end
   end

   // Look-ahead for the tone generator: high when the coming cycle is ON.
   assign w_tone_en = w_grant_go ||
                      ((r_state == S_ON) && !w_last_on && !w_abort) ||
                      (w_last_off && (r_beeps_left != '0) && !w_abort);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_pending    <= '0;
         r_active     <= '0;
         r_beeps_left <= '0;
         r_phase_cnt  <= '0;
         r_done       <= '0;
      end else begin
         r_pending <= w_pend_next;
         r_done    <= '0;
         if (w_abort) begin
            r_state      <= S_IDLE;
            r_active     <= '0;
            r_beeps_left <= '0;
            r_phase_cnt  <= '0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (w_grant_go) begin
                     r_active     <= w_grant_idx;
                     r_beeps_left <= BW'(w_grant_idx) + BW'(1);
                     r_phase_cnt  <= '0;
                     r_state      <= S_ON;
                  end
               end
               S_ON: begin
                  if (w_last_on) begin
                     r_state      <= S_OFF;
                     r_phase_cnt  <= '0;
                     r_beeps_left <= r_beeps_left - BW'(1);
                  end else begin
                     r_phase_cnt <= r_phase_cnt + CW'(1);
                  end
               end
               S_OFF: begin
                  if (w_last_off) begin
                     r_phase_cnt <= '0;
                     if (r_beeps_left != '0) begin
                        r_state <= S_ON;
                     end else begin
                        r_state          <= S_IDLE;
                        r_done[r_active] <= 1'b1;
                        r_active         <= '0;
                     end
                  end else begin
                     r_phase_cnt <= r_phase_cnt + CW'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   beep_tone_gen #(
      .TONE_DIV (TONE_DIV)
   ) u_tone_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (w_tone_en),
      .tone (w_tone)
   );

   assign done    = r_done;
   assign busy    = (r_state != S_IDLE);
   assign active  = r_active;
   assign speaker = w_tone;

endmodule
